// File: rtl/icache.sv
// Direct-mapped instruction cache: 16-byte blocks, combinational hit path,
// single-block refill from instruction memory on a miss.
module icache #(
    parameter int INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  PC,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [5:0]   MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);
    localparam int BLOCKS = 1 << INDEX_BITS;
    localparam int TAG_W  = 6 - INDEX_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [5:0]              fill_addr_q, fill_addr_d;
    logic [BLOCKS-1:0]       valid_q, valid_d;
    logic [TAG_W-1:0]        tag_q  [BLOCKS];
    logic [127:0]            data_q [BLOCKS];

    logic [INDEX_BITS-1:0]   pc_index;
    logic [TAG_W-1:0]        pc_tag;
    logic [1:0]              pc_offset;
    logic [INDEX_BITS-1:0]   fill_index;
    logic [TAG_W-1:0]        fill_tag;
    logic                    fill_done;
    logic                    hit;
    logic [127:0]            hit_block;
    logic                    unused_pc;

    assign pc_offset  = PC[3:2];
    assign pc_index   = PC[4 +: INDEX_BITS];
    assign pc_tag     = PC[9 -: TAG_W];
    assign fill_index = fill_addr_q[INDEX_BITS-1:0];
    assign fill_tag   = fill_addr_q[5 -: TAG_W];
    assign unused_pc  = ^{PC[31:10], PC[1:0]};

    assign hit       = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
    assign hit_block = data_q[pc_index];
    assign fill_done = (state_q == READ) && !MEM_BUSYWAIT;

    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        valid_d     = valid_q;
        case (state_q)
            IDLE: begin
                if (!hit) begin
                    state_d     = READ;
                    fill_addr_d = PC[9:4];
                end
            end
            READ: begin
                if (!MEM_BUSYWAIT) begin
                    state_d             = IDLE;
                    valid_d[fill_index] = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            fill_addr_q <= 6'd0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            valid_q     <= valid_d;
        end
    end

    // Data and tags need no reset: valid bits alone decide whether they are used.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            data_q[fill_index] <= MEM_READDATA;
            tag_q[fill_index]  <= fill_tag;
        end
    end

    assign MEM_READ    = (state_q == READ);
    assign MEM_ADDRESS = (state_q == READ) ? fill_addr_q : PC[9:4];
    // Gated by RESET so the CPU is not stalled while the cache is held in reset.
    assign BUSYWAIT    = RESET && (MEM_READ || !hit);
    assign INSTRUCTION = hit ? hit_block[{pc_offset, 5'b00000} +: 32] : 32'h0;

endmodule

// File: tb/tb_icache.sv
// Randomized and directed bench for icache against a block-residency model
// and an L=4 instruction memory returning 0xB000_0000 | byte address.
module tb_icache;
    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;

    int passed = 0;
    int total  = 0;
    int mem_cnt = 0;
    int fills = 0;
    int resident [8];

    always #10 CLK = ~CLK;

    icache dut (
        .CLK(CLK),
        .RESET(RESET),
        .PC(PC),
        .INSTRUCTION(INSTRUCTION),
        .BUSYWAIT(BUSYWAIT),
        .MEM_READ(MEM_READ),
        .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_READDATA(MEM_READDATA),
        .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    // Memory: busy for the first 4 cycles of a request, data valid only on completion.
    always @(posedge CLK) begin
        if (MEM_READ && !MEM_BUSYWAIT) fills <= fills + 1;
        mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
    end
    assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < 4);
    always_comb begin
        MEM_READDATA = {4{32'hDEAD_BEEF}};
        if (!MEM_BUSYWAIT)
            for (int k = 0; k < 4; k++)
                MEM_READDATA[32*k +: 32] = 32'hB000_0000 | ({22'd0, MEM_ADDRESS, 4'd0} + 32'(4*k));
    end

    function automatic bit model_miss(input logic [31:0] pc);
        return resident[pc[6:4]] != int'(pc[9:4]);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] pc);
        return 32'hB000_0000 | {22'd0, pc[9:2], 2'b00};
    endfunction

    task automatic model_clear();
        foreach (resident[i]) resident[i] = -1;
    endtask

    task automatic model_fill(input logic [31:0] pc);
        resident[pc[6:4]] = int'(pc[9:4]);
    endtask

    // Observes one fetch from the current cycle until BUSYWAIT drops; no comparisons.
    task automatic measure(output int busy, output int mread, output logic [5:0] addr,
                           output logic [31:0] instr, output bit timeout);
        busy = 0; mread = 0; addr = 'x; instr = 'x; timeout = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (BUSYWAIT === 1'b1) busy++;
            if (MEM_READ === 1'b1) begin
                if (mread == 0) addr = MEM_ADDRESS;
                mread++;
            end
            if (BUSYWAIT === 1'b0) begin
                instr = INSTRUCTION;
                timeout = 1'b0;
                break;
            end
        end
        @(posedge CLK); #1;
    endtask

    task automatic apply_reset(input logic [31:0] pc);
        @(posedge CLK); #1;
        PC = pc;
        RESET = 1'b0;
        #5;
        RESET = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        PC = $urandom;
        #1 RESET = 1'b0;
        #5;
        total++; if (BUSYWAIT !== 1'b0) $display("FAIL reset_busywait got %b want 0", BUSYWAIT); else passed++;
        total++; if (MEM_READ !== 1'b0) $display("FAIL reset_mem_read got %b want 0", MEM_READ); else passed++;
        total++; if (INSTRUCTION !== 32'h0) $display("FAIL reset_instruction got %h want 0", INSTRUCTION); else passed++;
        PC = 32'h0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(negedge CLK);
        total++; if (BUSYWAIT !== 1'b1 || MEM_READ !== 1'b0)
            $display("FAIL reset_detect busywait=%b mem_read=%b want 1/0", BUSYWAIT, MEM_READ); else passed++;
        @(negedge CLK);
        total++; if (MEM_READ !== 1'b1 || MEM_ADDRESS !== 6'd0)
            $display("FAIL reset_first_read mem_read=%b addr=%0d want 1/0", MEM_READ, MEM_ADDRESS); else passed++;
        $display("reset: outputs cleared, cold miss issued");
    endtask

    task automatic test_cold_miss();
        logic [31:0] pcs [4] = '{32'h000, 32'h004, 32'h008, 32'h00C};
        int busy, mread; logic [5:0] addr; logic [31:0] instr; bit to, miss;
        apply_reset(pcs[0]);
        foreach (pcs[i]) begin
            PC = pcs[i]; miss = model_miss(pcs[i]);
            measure(busy, mread, addr, instr, to);
            total++; if (to || busy != (miss ? 6 : 0)) $display("FAIL cold_busy pc=%h got %0d want %0d", pcs[i], busy, miss ? 6 : 0); else passed++;
            total++; if (mread != (miss ? 5 : 0)) $display("FAIL cold_mread pc=%h got %0d want %0d", pcs[i], mread, miss ? 5 : 0); else passed++;
            total++; if (instr !== model_word(pcs[i])) $display("FAIL cold_instr pc=%h got %h want %h", pcs[i], instr, model_word(pcs[i])); else passed++;
            model_fill(pcs[i]);
            $display("cold: pc=%h miss=%0d busy=%0d instr=%h", pcs[i], miss, busy, instr);
        end
    endtask

    task automatic test_conflict();
        logic [31:0] pcs [3] = '{32'h000, 32'h080, 32'h000};
        int busy, mread; logic [5:0] addr; logic [31:0] instr; bit to, miss;
        apply_reset(pcs[0]);
        foreach (pcs[i]) begin
            PC = pcs[i]; miss = model_miss(pcs[i]);
            measure(busy, mread, addr, instr, to);
            total++; if (to || busy != (miss ? 6 : 0)) $display("FAIL conflict_busy pc=%h got %0d want %0d", pcs[i], busy, miss ? 6 : 0); else passed++;
            total++; if (miss && addr !== pcs[i][9:4]) $display("FAIL conflict_addr pc=%h got %0d want %0d", pcs[i], addr, pcs[i][9:4]); else passed++;
            total++; if (instr !== model_word(pcs[i])) $display("FAIL conflict_instr pc=%h got %h want %h", pcs[i], instr, model_word(pcs[i])); else passed++;
            model_fill(pcs[i]);
            $display("conflict: pc=%h miss=%0d addr=%0d instr=%h", pcs[i], miss, addr, instr);
        end
    endtask

    task automatic test_cross_index();
        logic [31:0] pcs [4] = '{32'h000, 32'h010, 32'h000, 32'h403};
        int busy, mread; logic [5:0] addr; logic [31:0] instr; bit to, miss;
        apply_reset(pcs[0]);
        foreach (pcs[i]) begin
            PC = pcs[i]; miss = model_miss(pcs[i]);
            measure(busy, mread, addr, instr, to);
            total++; if (to || busy != (miss ? 6 : 0)) $display("FAIL xindex_busy pc=%h got %0d want %0d", pcs[i], busy, miss ? 6 : 0); else passed++;
            total++; if (miss && addr !== pcs[i][9:4]) $display("FAIL xindex_addr pc=%h got %0d want %0d", pcs[i], addr, pcs[i][9:4]); else passed++;
            total++; if (instr !== model_word(pcs[i])) $display("FAIL xindex_instr pc=%h got %h want %h", pcs[i], instr, model_word(pcs[i])); else passed++;
            model_fill(pcs[i]);
            $display("xindex: pc=%h miss=%0d addr=%0d instr=%h", pcs[i], miss, addr, instr);
        end
    endtask

    task automatic test_reset_mid_fill();
        int busy, mread, f0; logic [5:0] addr; logic [31:0] instr; bit to;
        apply_reset(32'h000);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        #2;
        total++; if (MEM_READ !== 1'b0 || BUSYWAIT !== 1'b0)
            $display("FAIL midfill_drop mem_read=%b busywait=%b want 0/0", MEM_READ, BUSYWAIT); else passed++;
        f0 = fills;
        @(posedge CLK); #1;
        RESET = 1'b1;
        model_clear();
        measure(busy, mread, addr, instr, to);
        total++; if (to || busy != 6) $display("FAIL midfill_busy got %0d want 6", busy); else passed++;
        total++; if (mread != 5 || addr !== 6'd0) $display("FAIL midfill_read got %0d/%0d want 5/0", mread, addr); else passed++;
        total++; if (instr !== 32'hB000_0000) $display("FAIL midfill_instr got %h want b0000000", instr); else passed++;
        total++; if (fills != f0 + 1) $display("FAIL midfill_fills got %0d want %0d", fills - f0, 1); else passed++;
        model_fill(32'h000);
        $display("midfill: refill busy=%0d mread=%0d instr=%h", busy, mread, instr);
    endtask

    task automatic test_sweep();
        int busy, mread, f0; logic [5:0] addr; logic [31:0] instr; bit to, miss;
        logic [31:0] pc;
        apply_reset(32'h000);
        f0 = fills;
        for (int a = 0; a < 1024; a += 4) begin
            pc = 32'(a);
            PC = pc; miss = model_miss(pc);
            measure(busy, mread, addr, instr, to);
            total++; if (to || busy != (miss ? 6 : 0)) $display("FAIL sweep_busy pc=%h got %0d want %0d", pc, busy, miss ? 6 : 0); else passed++;
            total++; if (instr !== model_word(pc)) $display("FAIL sweep_instr pc=%h got %h want %h", pc, instr, model_word(pc)); else passed++;
            model_fill(pc);
            $display("sweep: pc=%h miss=%0d instr=%h", pc, miss, instr);
        end
        total++; if (fills - f0 != 64) $display("FAIL sweep_fills got %0d want 64", fills - f0); else passed++;
    endtask

    task automatic test_random();
        int busy, mread; logic [5:0] addr; logic [31:0] instr; bit to, miss;
        logic [31:0] pc;
        pc = 32'h0;
        apply_reset(pc);
        for (int n = 0; n < 60; n++) begin
            if (n > 0) begin
                pc = $urandom;
                pc[9:7] = 3'($urandom_range(0, 1));
                pc[6:4] = 3'($urandom_range(0, 3));
            end
            PC = pc; miss = model_miss(pc);
            measure(busy, mread, addr, instr, to);
            total++; if (to || busy != (miss ? 6 : 0)) $display("FAIL rand_busy pc=%h got %0d want %0d", pc, busy, miss ? 6 : 0); else passed++;
            total++; if (mread != (miss ? 5 : 0)) $display("FAIL rand_mread pc=%h got %0d want %0d", pc, mread, miss ? 5 : 0); else passed++;
            total++; if (miss && addr !== pc[9:4]) $display("FAIL rand_addr pc=%h got %0d want %0d", pc, addr, pc[9:4]); else passed++;
            total++; if (instr !== model_word(pc)) $display("FAIL rand_instr pc=%h got %h want %h", pc, instr, model_word(pc)); else passed++;
            model_fill(pc);
            $display("rand: pc=%h miss=%0d busy=%0d instr=%h", pc, miss, busy, instr);
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_cold_miss();
        test_conflict();
        test_cross_index();
        test_reset_mid_fill();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache between the CPU fetch port and the 1 KiB instruction memory. It replaces the combinational byte-array fetch with a 16-byte-block cache. On a hit it returns the 32-bit word in the same cycle. On a miss it stalls the CPU through `BUSYWAIT`, reads one 128-bit block from instruction memory over a MEM_READ/MEM_BUSYWAIT handshake, then serves the word.

## Interface
- `INDEX_BITS`, default 3. Log2 of the block count (8 blocks). Tag width = 6 − INDEX_BITS. Supported range 1..5; only the default is verified.
- `CLK`  in  1  Clock. All state updates on the rising edge.
- `RESET`  in  1  Asynchronous, active-low reset.
- `PC`  in  32  Fetch address from the CPU.
  - Only PC[9:0] is used; PC[1:0] is ignored (word-aligned).
  - The CPU holds PC stable while `BUSYWAIT`=1.
- `INSTRUCTION`  out  32  Fetched word. Valid when `BUSYWAIT`=0.
- `BUSYWAIT`  out  1  Stall request to the CPU.
- `MEM_READ`  out  1  Block read request to instruction memory.
- `MEM_ADDRESS`  out  6  Block address, equal to byte address[9:4].
- `MEM_READDATA`  in  128  Block data.
  - Word k occupies bits [32k+31:32k].
  - Within each word, byte 0 is the LSB (little-endian, as the CPU expects).
- `MEM_BUSYWAIT`  in  1  Memory busy.
  - Memory raises it in the same cycle `MEM_READ` rises and holds it for L ≥ 1 cycles.
  - It is then low for exactly the completion cycle, during which `MEM_READDATA` is valid.

## Operation
- Address split (default parameter): offset = PC[3:2] selects the word; index = PC[6:4]; tag = PC[9:7].
- Per-block storage: valid bit, tag, 128-bit data.
- hit = valid[index] AND (tag_store[index] == tag). Combinational from PC and stored arrays.
- `INSTRUCTION` = selected word of data[index] when hit; 32'h0 otherwise.
- State machine, 2 states:
  - IDLE:
    - `MEM_READ`=0.
    - `BUSYWAIT` = !hit.
    - On a rising edge with !hit: latch PC[9:4] into the fill-address register and go to READ.
  - READ:
    - `MEM_READ`=1, `MEM_ADDRESS` = fill-address register, `BUSYWAIT`=1.
    - On a rising edge with `MEM_BUSYWAIT`=0: write `MEM_READDATA` to data[fill index], write the fill tag, set valid, return to IDLE.
    - Otherwise stay in READ.
- In IDLE, `MEM_ADDRESS` = PC[9:4] (don't-care to memory).
- Replacement: the fill overwrites the indexed block unconditionally. No write path, no dirty bits.
- Reset, when `RESET`=0 (immediate, asynchronous):
  - State = IDLE, all valid bits = 0, fill-address register = 0.
  - Data and tag arrays: contents don't-care.
  - Outputs during reset: `BUSYWAIT`=0, `MEM_READ`=0, `INSTRUCTION`=0.
- Reset mid-fill: the READ state is abandoned and no valid bit is set. After reset release the same PC misses again and a fresh fill is issued.
- PC change while `BUSYWAIT`=1 violates the CPU contract. The fill still completes at the latched address; hit is then re-evaluated on the new PC.

## Timing
- Hit: 0-cycle latency; `INSTRUCTION` valid combinationally in the cycle PC is presented.
- Miss with memory busy length L:
  - `BUSYWAIT` is high for L+2 consecutive cycles: 1 detect cycle, L busy cycles, 1 completion cycle.
  - `MEM_READ` is high for L+1 cycles.
  - The hit is served in the next cycle.
- The first rising edge after `RESET` rises is a normal operating edge.
- Back-to-back misses: after a fill, a new miss re-enters READ on the edge following the IDLE detect cycle. There is always at least 1 cycle of `MEM_READ`=0 between fills.

## Test plan
Memory model for all scenarios: L=4. The block for address A returns words {A+12, A+8, A+4, A} encoded as 32'hB000_0000 | byte address.

- **Reset.** `RESET`=0 for 5 ns → `BUSYWAIT`=0, `MEM_READ`=0, `INSTRUCTION`=0 immediately. Release with PC=0 → cold miss; next edge `MEM_READ`=1, `MEM_ADDRESS`=0.
- **Cold miss then hits.** PC=0x000:
  - `BUSYWAIT` high 6 cycles, `MEM_READ` high 5 cycles, then `INSTRUCTION`=32'hB000_0000.
  - PC=0x004, 0x008, 0x00C each hit with `BUSYWAIT`=0; `INSTRUCTION` = 0xB000_0004, 0xB000_0008, 0xB000_000C.
- **Conflict eviction.** After filling 0x000, PC=0x080 misses:
  - `MEM_ADDRESS`=6'd8, `INSTRUCTION`=0xB000_0080 after the fill.
  - Returning to PC=0x000 misses again with `MEM_ADDRESS`=0.
- **No cross-index eviction and alignment.**
  - Fill 0x000, then 0x010 (`MEM_ADDRESS`=1).
  - PC=0x000 still hits (`BUSYWAIT`=0).
  - PC=0x0000_0403 hits and returns 0xB000_0000, since PC[31:10] and PC[1:0] are ignored.
- **Reset mid-fill.** Assert `RESET`=0 in the 2nd cycle of READ → `MEM_READ` drops immediately. After release PC=0x000 misses and a complete new fill is performed.
- **Full sweep.** PC = 0x000..0x3FC in steps of 4 → exactly 64 fills, one per block. Every `INSTRUCTION` equals 0xB000_0000 | PC.
